// File: rtl/coin_pkg.sv
// Coin encodings, coin values and dispenser states, shared by the change
// dispenser and the coin acceptor so both sides agree on the coin-type code.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_3    = 2'b10,
    COIN_10   = 2'b11
  } coin_e;

  localparam logic [3:0] VAL_1  = 4'd1;
  localparam logic [3:0] VAL_3  = 4'd3;
  localparam logic [3:0] VAL_10 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_OFFER  = 2'd2,
    ST_DONE   = 2'd3
  } disp_state_e;

  // Face value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [3:0] coin_val(input coin_e c);
    case (c)
      COIN_1:  return VAL_1;
      COIN_3:  return VAL_3;
      COIN_10: return VAL_10;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: one coin offered at a time, taken on valid & ready.
interface change_dispenser_if;
  import coin_pkg::*;

  logic  coin_valid;
  coin_e coin_type;
  logic  coin_ready;

  modport master (output coin_valid, output coin_type, input coin_ready);
  modport slave  (input coin_valid, input coin_type, output coin_ready);
endinterface

// File: rtl/coin_select.sv
// Greedy coin chooser: largest coin that fits in the remaining amount and
// is still in stock. found is low when nothing fits (including remaining==0).
module coin_select
  import coin_pkg::*;
#(
  parameter int STOCK_W = 4
) (
  input  logic [3:0]         remaining,
  input  logic [STOCK_W-1:0] stock_1,
  input  logic [STOCK_W-1:0] stock_3,
  input  logic [STOCK_W-1:0] stock_10,
  output coin_e              coin_type,
  output logic [3:0]         coin_value,
  output logic               found
);

  // Priority pick from the largest denomination down.
  always_comb begin
    coin_type = COIN_NONE;
    if (remaining >= VAL_10 && stock_10 != '0) begin
      coin_type = COIN_10;
    end else if (remaining >= VAL_3 && stock_3 != '0) begin
      coin_type = COIN_3;
    end else if (remaining >= VAL_1 && stock_1 != '0) begin
      coin_type = COIN_1;
    end
    found      = (coin_type != COIN_NONE);
    coin_value = coin_val(coin_type);
  end

endmodule

// File: rtl/change_dispenser.sv
// Refund path: pays a credit amount back as coins through the hopper,
// greedily, tracking per-denomination stock and reporting any shortfall.
// Outputs are registered; coin_valid and done follow the state by one cycle.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int STOCK_W       = 4,
  parameter int STOCK_INIT_1  = 8,
  parameter int STOCK_INIT_3  = 4,
  parameter int STOCK_INIT_10 = 2
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                refund_req,
  input  logic [3:0]          refund_amt,
  output logic                refund_ack,
  input  logic                restock,
  change_dispenser_if.master  hop,
  output logic                busy,
  output logic                done,
  output logic [3:0]          shortfall,
  output logic [STOCK_W-1:0]  stock_1,
  output logic [STOCK_W-1:0]  stock_3,
  output logic [STOCK_W-1:0]  stock_10
);

  localparam logic [STOCK_W-1:0] INIT_1  = STOCK_W'(STOCK_INIT_1);
  localparam logic [STOCK_W-1:0] INIT_3  = STOCK_W'(STOCK_INIT_3);
  localparam logic [STOCK_W-1:0] INIT_10 = STOCK_W'(STOCK_INIT_10);
  localparam logic [STOCK_W-1:0] ONE     = STOCK_W'(1);

  disp_state_e        state_q, state_d;
  logic [3:0]         remaining_q, remaining_d;
  logic               coin_valid_q, coin_valid_d;
  coin_e              coin_type_q, coin_type_d;
  logic               refund_ack_q, refund_ack_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [3:0]         shortfall_q, shortfall_d;
  logic [STOCK_W-1:0] s1_q, s1_d, s3_q, s3_d, s10_q, s10_d;

  coin_e      sel_type;
  logic [3:0] sel_value;
  logic       sel_found;
  logic       handshake;

  coin_select #(.STOCK_W(STOCK_W)) u_sel (
    .remaining  (remaining_q),
    .stock_1    (s1_q),
    .stock_3    (s3_q),
    .stock_10   (s10_q),
    .coin_type  (sel_type),
    .coin_value (sel_value),
    .found      (sel_found)
  );

  assign handshake = coin_valid_q && hop.coin_ready;

  // State and datapath registers; reset drops any in-flight coin untouched.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_valid_q <= 1'b0;
      coin_type_q  <= COIN_NONE;
      refund_ack_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      shortfall_q  <= '0;
      s1_q         <= INIT_1;
      s3_q         <= INIT_3;
      s10_q        <= INIT_10;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      refund_ack_q <= refund_ack_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      shortfall_q  <= shortfall_d;
      s1_q         <= s1_d;
      s3_q         <= s3_d;
      s10_q        <= s10_d;
    end
  end

  // Next-state: a coin offer returns to SELECT once the hopper takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (refund_req) state_d = ST_SELECT;
      ST_SELECT: state_d = sel_found ? ST_OFFER : ST_DONE;
      ST_OFFER:  if (handshake) state_d = ST_SELECT;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath updates for the registered outputs.
  always_comb begin
    remaining_d  = remaining_q;
    coin_valid_d = 1'b0;
    coin_type_d  = coin_type_q;
    refund_ack_d = 1'b0;
    done_d       = (state_q == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
    shortfall_d  = shortfall_q;
    s1_d         = s1_q;
    s3_d         = s3_q;
    s10_d        = s10_q;
    case (state_q)
      ST_IDLE: begin
        if (restock) begin
          s1_d  = INIT_1;
          s3_d  = INIT_3;
          s10_d = INIT_10;
        end
        if (refund_req) begin
          remaining_d  = refund_amt;
          shortfall_d  = '0;
          refund_ack_d = 1'b1;
        end
      end
      ST_SELECT: begin
        if (sel_found) coin_type_d = sel_type;
        else           shortfall_d = remaining_q;
      end
      ST_OFFER: begin
        // remaining and stock are frozen during OFFER, so the selector
        // still presents the value of the coin being offered.
        if (handshake) begin
          remaining_d = remaining_q - sel_value;
          coin_type_d = COIN_NONE;
          case (coin_type_q)
            COIN_1:  s1_d  = s1_q - ONE;
            COIN_3:  s3_d  = s3_q - ONE;
            COIN_10: s10_d = s10_q - ONE;
            default: ;
          endcase
        end else begin
          coin_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign hop.coin_valid = coin_valid_q;
  assign hop.coin_type  = coin_type_q;
  assign refund_ack     = refund_ack_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign shortfall      = shortfall_q;
  assign stock_1        = s1_q;
  assign stock_3        = s3_q;
  assign stock_10       = s10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random refunds checked
// against a greedy payout model kept as plain integer stock counts.
module tb_change_dispenser;
  import coin_pkg::*;

  localparam int SW  = 4;
  localparam int I1  = 8;
  localparam int I3  = 4;
  localparam int I10 = 2;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          refund_req = 1'b0;
  logic [3:0]    refund_amt = 4'd0;
  logic          restock = 1'b0;
  logic          refund_ack, busy, done;
  logic [3:0]    shortfall;
  logic [SW-1:0] stock_1, stock_3, stock_10;

  change_dispenser_if hop_if();

  change_dispenser #(
    .STOCK_W(SW), .STOCK_INIT_1(I1), .STOCK_INIT_3(I3), .STOCK_INIT_10(I10)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .refund_req (refund_req),
    .refund_amt (refund_amt),
    .refund_ack (refund_ack),
    .restock    (restock),
    .hop        (hop_if),
    .busy       (busy),
    .done       (done),
    .shortfall  (shortfall),
    .stock_1    (stock_1),
    .stock_3    (stock_3),
    .stock_10   (stock_10)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m1, m3, m10;
  int exp_q[$];
  int got_q[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Greedy payout on the model stock: largest affordable coin each step.
  // Coin codes: 3 = ten, 2 = three, 1 = one. Returns the unpaid remainder.
  function automatic int model_pay(input int amt);
    int rem = amt;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (rem >= 10 && m10 > 0) begin
        exp_q.push_back(3); rem -= 10; m10--;
      end else if (rem >= 3 && m3 > 0) begin
        exp_q.push_back(2); rem -= 3; m3--;
      end else if (rem >= 1 && m1 > 0) begin
        exp_q.push_back(1); rem -= 1; m1--;
      end
    end
    return rem;
  endfunction

  task automatic model_reset();
    m1 = I1; m3 = I3; m10 = I10;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(hop_if.coin_valid), 0);
    check_eq({tag, "_type"}, int'(hop_if.coin_type), 0);
    check_eq({tag, "_ack"}, int'(refund_ack), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_short"}, int'(shortfall), 0);
    check_eq({tag, "_s1"}, int'(stock_1), I1);
    check_eq({tag, "_s3"}, int'(stock_3), I3);
    check_eq({tag, "_s10"}, int'(stock_10), I10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    refund_req = 1'b0;
    restock = 1'b0;
    hop_if.coin_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    model_reset();
  endtask

  // One refund: rs_req restocks alongside the request, stall holds ready low
  // for that many cycles on the first offer, rs_busy drives restock while busy.
  task automatic run_refund(input int amt, input bit rs_req, input int stall,
                            input bit rs_busy);
    int exp_sf, k, done_k, first_k, n_ack, stall_left, p1, p3, p10;
    if (rs_req) model_reset();
    p1 = m1; p3 = m3; p10 = m10;
    exp_sf = model_pay(amt);
    got_q.delete();
    @(negedge clk);
    refund_req = 1'b1;
    refund_amt = amt[3:0];
    restock    = rs_req;
    @(negedge clk);
    refund_req = 1'b0;
    restock    = rs_busy;
    k = 1; done_k = 0; first_k = 0; n_ack = 0; stall_left = stall;
    while (k < 300 && done_k == 0) begin
      if (refund_ack) n_ack++;
      if (done) begin
        done_k  = k;
        restock = 1'b0;
      end else begin
        check_eq("busy", int'(busy), 1);
        if (hop_if.coin_valid) begin
          if (first_k == 0) first_k = k;
          check_eq("offer_type", int'(hop_if.coin_type),
                   (got_q.size() < exp_q.size()) ? exp_q[got_q.size()] : 0);
          if (stall_left > 0) begin
            hop_if.coin_ready = 1'b0;
            stall_left--;
            check_eq("stall_stock", int'({stock_1, stock_3, stock_10}),
                     (p1 << 8) | (p3 << 4) | p10);
          end else begin
            hop_if.coin_ready = 1'b1;
            got_q.push_back(int'(hop_if.coin_type));
          end
        end else begin
          hop_if.coin_ready = 1'b0;
        end
      end
      @(negedge clk);
      k++;
    end
    hop_if.coin_ready = 1'b0;
    restock = 1'b0;
    if (done_k == 0) check_eq("done_timeout", 0, 1);
    check_eq("ack_count", n_ack, 1);
    check_eq("coin_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq("coin_seq", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    if (exp_q.size() > 0) check_eq("first_valid_lat", first_k, 3);
    else begin
      check_eq("zero_done_lat", done_k, 3);
      check_eq("zero_no_valid", first_k, 0);
    end
    check_eq("shortfall", int'(shortfall), exp_sf);
    check_eq("stock_1", int'(stock_1), m1);
    check_eq("stock_3", int'(stock_3), m3);
    check_eq("stock_10", int'(stock_10), m10);
    check_eq("idle_busy", int'(busy), 0);
  endtask

  // Pull reset while a coin is being offered and held back by the hopper.
  task automatic reset_during_offer();
    int w;
    @(negedge clk);
    refund_req = 1'b1;
    refund_amt = 4'd13;
    @(negedge clk);
    refund_req = 1'b0;
    hop_if.coin_ready = 1'b0;
    w = 0;
    while (!hop_if.coin_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_offer_seen", int'(hop_if.coin_valid), 1);
    #2 clr_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
  endtask

  initial begin
    hop_if.coin_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    clr_n = 1'b1;

    run_refund(14, 1'b0, 0, 1'b0);

    do_reset();
    run_refund(13, 1'b0, 5, 1'b0);

    do_reset();
    run_refund(10, 1'b0, 0, 1'b0);
    run_refund(10, 1'b0, 0, 1'b0);
    run_refund(10, 1'b0, 0, 1'b0);

    for (int i = 0; i < 12 && (m1 + m3 + m10) > 0; i++)
      run_refund(15, 1'b0, 0, 1'b0);
    run_refund(5, 1'b0, 0, 1'b0);
    run_refund(5, 1'b1, 0, 1'b0);

    run_refund(0, 1'b0, 0, 1'b0);

    run_refund(7, 1'b0, 1, 1'b1);

    for (int i = 0; i < 40; i++)
      run_refund($urandom_range(0, 15), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1);

    reset_during_offer();
    run_refund(14, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
